// File: rtl/phy_freelist_if.sv
// phy_freelist_if: rename-stage free-list bundle (allocate, commit release, status).
interface phy_freelist_if #(parameter int PHY_SEL = 6, parameter int FL_SEL = 5);
   logic alloc_req1, alloc_req2, stall_DP, flush;
   logic commit_valid1, commit_valid2;
   logic [4:0] commit_dst_1, commit_dst_2;
   logic [PHY_SEL-1:0] commit_release_tag_1, commit_release_tag_2;
   logic [PHY_SEL-1:0] alloc_tag_1, alloc_tag_2;
   logic allocatable;
   logic [FL_SEL:0] free_count;
   logic double_free_err;
   modport master (
      output alloc_req1, alloc_req2, stall_DP, flush,
      output commit_valid1, commit_valid2, commit_dst_1, commit_dst_2,
      output commit_release_tag_1, commit_release_tag_2,
      input alloc_tag_1, alloc_tag_2, allocatable, free_count, double_free_err
   );
   modport slave (
      input alloc_req1, alloc_req2, stall_DP, flush,
      input commit_valid1, commit_valid2, commit_dst_1, commit_dst_2,
      input commit_release_tag_1, commit_release_tag_2,
      output alloc_tag_1, alloc_tag_2, allocatable, free_count, double_free_err
   );
endinterface

// File: rtl/phy_freelist.sv
// phy_freelist: dual-pop/dual-push physical tag free list with flush recovery.
// FREELIST_DUP_CHECK_EN adds a free-bit vector and a sticky double_free_err.
module phy_freelist #(
   parameter int PHY_NUM  = 64,
   parameter int PHY_SEL  = $clog2(PHY_NUM),
   parameter int ARCH_NUM = 32,
   parameter int FL_NUM   = PHY_NUM - ARCH_NUM,
   parameter int FL_SEL   = $clog2(FL_NUM)
) (
   input logic clk,
   input logic reset_n,
   phy_freelist_if.slave bus
);
   logic [PHY_SEL-1:0] fl [FL_NUM];
   logic [FL_SEL-1:0] head, arch_head, tail, arch_next, diff;
   logic [FL_SEL:0] count, reqnum, popnum, relnum, inflight, count_next;
   logic rel1, rel2, pop;
   always_comb begin
      rel1 = bus.commit_valid1 & (bus.commit_dst_1 != 5'd0);
      rel2 = bus.commit_valid2 & (bus.commit_dst_2 != 5'd0);
      reqnum = {{(FL_SEL-1){1'b0}}, bus.alloc_req1 & bus.alloc_req2, bus.alloc_req1 & ~bus.alloc_req2};
      relnum = {{(FL_SEL-1){1'b0}}, rel1 & rel2, rel1 ^ rel2};
      bus.allocatable = count >= reqnum;
      pop = ~bus.flush & ~bus.stall_DP & bus.allocatable;
      popnum = pop ? reqnum : '0;
      arch_next = arch_head + relnum[FL_SEL-1:0];
      diff = head - arch_next;
      // equal pointers with nothing free means every tag is in flight
      inflight = (diff == '0 && count == '0) ? (FL_SEL+1)'(FL_NUM) : {1'b0, diff};
      count_next = bus.flush ? count + inflight + relnum : count - popnum + relnum;
      bus.alloc_tag_1 = fl[head];
      bus.alloc_tag_2 = fl[head + FL_SEL'(1)];
      bus.free_count = count;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < FL_NUM; i++) fl[i] <= PHY_SEL'(ARCH_NUM + i);
         head <= '0;
         arch_head <= '0;
         tail <= '0;
         count <= (FL_SEL+1)'(FL_NUM);
      end else begin
         if (rel1) fl[tail] <= bus.commit_release_tag_1;
         if (rel2) fl[tail + FL_SEL'(rel1)] <= bus.commit_release_tag_2;
         tail <= tail + relnum[FL_SEL-1:0];
         arch_head <= arch_next;
         head <= bus.flush ? arch_next : head + popnum[FL_SEL-1:0];
         count <= count_next;
      end
   end
`ifdef FREELIST_DUP_CHECK_EN
   logic [PHY_NUM-1:0] free_vec, free_next;
   logic err, dup;
   always_comb begin
      free_next = free_vec;
      for (int i = 0; i < FL_NUM; i++)
         if (bus.flush && {1'b0, FL_SEL'(i) - arch_next} < inflight) free_next[fl[i]] = 1'b1;
      if (pop && bus.alloc_req1) free_next[fl[head]] = 1'b0;
      if (pop && bus.alloc_req2) free_next[fl[head + FL_SEL'(1)]] = 1'b0;
      if (rel1) free_next[bus.commit_release_tag_1] = 1'b1;
      if (rel2) free_next[bus.commit_release_tag_2] = 1'b1;
      dup = (rel1 && free_vec[bus.commit_release_tag_1]) || (rel2 && free_vec[bus.commit_release_tag_2])
         || (rel1 && rel2 && bus.commit_release_tag_1 == bus.commit_release_tag_2)
         || (!bus.flush && count_next > (FL_SEL+1)'(FL_NUM));
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         free_vec <= {{FL_NUM{1'b1}}, {ARCH_NUM{1'b0}}};
         err <= 1'b0;
      end else begin
         free_vec <= free_next;
         err <= err | dup;
      end
   end
   assign bus.double_free_err = err;
`else
   assign bus.double_free_err = 1'b0;
`endif
endmodule

// File: tb/tb_phy_freelist.sv
// tb_phy_freelist: directed checks of pop, push, empty, flush recovery and wrap.
module tb_phy_freelist;
   logic clk = 1'b0;
   logic reset_n;
   int errors = 0;
   int checks = 0;
`ifdef FREELIST_DUP_CHECK_EN
   localparam int DUP = 1;
`else
   localparam int DUP = 0;
`endif
   phy_freelist_if #(.PHY_SEL(6), .FL_SEL(5)) bus ();
   phy_freelist dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(string tag, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.alloc_req1 = 0; bus.alloc_req2 = 0; bus.stall_DP = 0; bus.flush = 0;
      bus.commit_valid1 = 0; bus.commit_valid2 = 0;
      bus.commit_dst_1 = 0; bus.commit_dst_2 = 0;
      bus.commit_release_tag_1 = 0; bus.commit_release_tag_2 = 0;
   endtask
   task automatic commit(bit v1, int d1, int t1, bit v2, int d2, int t2);
      bus.commit_valid1 = v1; bus.commit_dst_1 = 5'(d1); bus.commit_release_tag_1 = 6'(t1);
      bus.commit_valid2 = v2; bus.commit_dst_2 = 5'(d2); bus.commit_release_tag_2 = 6'(t2);
   endtask
   task automatic do_reset();
      reset_n = 0;
      tick();
      tick();
      reset_n = 1;
      #1;
   endtask
   initial begin
      idle();
      do_reset();
      check("rst_count", bus.free_count, 32);
      check("rst_tag1", bus.alloc_tag_1, 32);
      check("rst_tag2", bus.alloc_tag_2, 33);
      check("rst_alloc", bus.allocatable, 1);
      check("rst_err", bus.double_free_err, 0);
      for (int k = 0; k < 16; k++) begin
         bus.alloc_req1 = 1; bus.alloc_req2 = 1;
         #1;
         check("drain_tag1", bus.alloc_tag_1, 32 + 2 * k);
         check("drain_tag2", bus.alloc_tag_2, 33 + 2 * k);
         check("drain_alloc", bus.allocatable, 1);
         tick();
      end
      idle();
      #1;
      check("empty_count", bus.free_count, 0);
      check("empty_req0_alloc", bus.allocatable, 1);
      bus.alloc_req1 = 1;
      #1;
      check("empty_req1_alloc", bus.allocatable, 0);
      tick();
      check("empty_hold_count", bus.free_count, 0);
      check("empty_hold_tag1", bus.alloc_tag_1, 32);
      commit(1, 5, 7, 0, 0, 0);
      #1;
      check("nobypass_alloc", bus.allocatable, 0);
      tick();
      idle();
      #1;
      check("push1_count", bus.free_count, 1);
      check("push1_tag1", bus.alloc_tag_1, 7);
      commit(1, 0, 9, 1, 3, 12);
      tick();
      idle();
      #1;
      check("dst0_count", bus.free_count, 2);
      check("dst0_tag1", bus.alloc_tag_1, 7);
      check("dst0_tag2", bus.alloc_tag_2, 12);
      do_reset();
      bus.stall_DP = 1; bus.alloc_req1 = 1; bus.alloc_req2 = 1;
      tick();
      check("stall_count", bus.free_count, 32);
      check("stall_tag1", bus.alloc_tag_1, 32);
      bus.stall_DP = 0;
      tick();
      tick();
      idle();
      #1;
      check("pop4_count", bus.free_count, 28);
      check("pop4_tag1", bus.alloc_tag_1, 36);
      bus.flush = 1;
      commit(1, 4, 2, 0, 0, 0);
      tick();
      idle();
      #1;
      check("flush_tag1", bus.alloc_tag_1, 33);
      check("flush_tag2", bus.alloc_tag_2, 34);
      check("flush_count", bus.free_count, 32);
      for (int k = 0; k < 16; k++) begin
         int i1, i2;
         i1 = (1 + 2 * k) % 32;
         i2 = (2 + 2 * k) % 32;
         bus.alloc_req1 = 1; bus.alloc_req2 = 1;
         #1;
         check("wrap_tag1", bus.alloc_tag_1, i1 == 0 ? 2 : 32 + i1);
         check("wrap_tag2", bus.alloc_tag_2, i2 == 0 ? 2 : 32 + i2);
         tick();
      end
      idle();
      #1;
      check("wrap_count", bus.free_count, 0);
      do_reset();
      commit(1, 1, 40, 0, 0, 0);
      tick();
      idle();
      #1;
      check("dup_err", bus.double_free_err, DUP);
      tick();
      check("dup_sticky", bus.double_free_err, DUP);
      do_reset();
      check("dup_clear", bus.double_free_err, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
